mem_stage: RTL

//  Memory stage, directly downstream of the EX/MEM pipeline register. Takes the

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } mem_state_t;

    localparam int TIMEOUT_DEFAULT = 64;

    function automatic logic is_misaligned(input logic [15:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating access-age counter; flags the last permitted WAIT cycle.
module mem_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to a stallable memory and registers MEM/WB.
//  state  | meaning
//  IDLE   | accepting EX/MEM; single-cycle ops and zero-wait accesses finish here
//  WAIT   | request outstanding, pipeline frozen, age counter running
//  HALTED | halt retired; pipeline frozen until reset
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic [15:0] Addr_m,
    input  logic [15:0] WriteData_m,
    input  logic        MemRead_m,
    input  logic        MemWrite_m,
    input  logic        MemToReg_m,
    input  logic        RegWrite_m,
    input  logic [2:0]  WbReg_m,
    input  logic        halt_m,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall_m,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_reg,
    output logic        wb_regwrite,
    output logic        halt_wb,
    output logic        err_wb
);

    mem_state_t state, state_nxt;

    logic [15:0] cap_addr, cap_wdata;
    logic        cap_wr, cap_load_sel, cap_regwrite;
    logic [2:0]  cap_reg;
    logic        capture;

    logic        req_en, req_wr, stall_int;
    logic [15:0] req_addr, req_wdata;

    logic        wb_valid_n, wb_regwrite_n, halt_wb_n, err_wb_n;
    logic [15:0] wb_data_n;
    logic [2:0]  wb_reg_n;

    logic        expired;
    logic        mem_op;

    assign mem_op = MemRead_m | MemWrite_m;

    mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nxt != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        capture       = 1'b0;
        req_en        = 1'b0;
        req_wr        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        stall_int     = 1'b0;
        wb_valid_n    = 1'b0;
        wb_data_n     = '0;
        wb_reg_n      = '0;
        wb_regwrite_n = 1'b0;
        halt_wb_n     = 1'b0;
        err_wb_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                wb_data_n = Addr_m;
                wb_reg_n  = WbReg_m;
                if (valid_m) begin
                    if (halt_m) begin
                        wb_valid_n    = 1'b1;
                        wb_regwrite_n = RegWrite_m;
                        halt_wb_n     = 1'b1;
                        state_nxt     = ST_HALTED;
                    end else if (!mem_op) begin
                        wb_valid_n    = 1'b1;
                        wb_regwrite_n = RegWrite_m;
                    end else if (is_misaligned(Addr_m)) begin
                        wb_valid_n = 1'b1;
                        err_wb_n   = 1'b1;
                    end else begin
                        req_en    = 1'b1;
                        req_wr    = MemWrite_m;
                        req_addr  = Addr_m;
                        req_wdata = WriteData_m;
                        if (mem_done) begin
                            wb_valid_n    = 1'b1;
                            wb_regwrite_n = RegWrite_m;
                            if (MemRead_m && MemToReg_m) wb_data_n = mem_rdata;
                        end else begin
                            stall_int = 1'b1;
                            capture   = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                req_en    = 1'b1;
                req_wr    = cap_wr;
                req_addr  = cap_addr;
                req_wdata = cap_wdata;
                wb_data_n = cap_addr;
                wb_reg_n  = cap_reg;
                // A completion in the last permitted cycle beats the timeout.
                if (mem_done) begin
                    wb_valid_n    = 1'b1;
                    wb_regwrite_n = cap_regwrite;
                    if (cap_load_sel) wb_data_n = mem_rdata;
                    state_nxt     = ST_IDLE;
                end else if (expired) begin
                    wb_valid_n = 1'b1;
                    err_wb_n   = 1'b1;
                    state_nxt  = ST_IDLE;
                end else begin
                    stall_int = 1'b1;
                end
            end
            ST_HALTED: begin
                stall_int = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_wr       <= 1'b0;
            cap_load_sel <= 1'b0;
            cap_regwrite <= 1'b0;
            cap_reg      <= '0;
        end else if (capture) begin
            cap_addr     <= Addr_m;
            cap_wdata    <= WriteData_m;
            cap_wr       <= MemWrite_m;
            cap_load_sel <= MemRead_m & MemToReg_m;
            cap_regwrite <= RegWrite_m;
            cap_reg      <= WbReg_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_reg      <= '0;
            wb_regwrite <= 1'b0;
            halt_wb     <= 1'b0;
            err_wb      <= 1'b0;
        end else begin
            wb_valid    <= wb_valid_n;
            wb_data     <= wb_data_n;
            wb_reg      <= wb_reg_n;
            wb_regwrite <= wb_regwrite_n;
            halt_wb     <= halt_wb_n;
            err_wb      <= err_wb_n;
        end
    end

    // Reset must silence the memory and the upstream freeze without waiting for a clock.
    assign mem_en    = rst & req_en;
    assign stall_m   = rst & stall_int;
    assign mem_wr    = req_wr;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

endmodule
